// File: rtl/rv32_fetch_ctrl.sv
// rv32_fetch_ctrl: instruction-fetch sequencer with one outstanding request,
// a 2-entry PC/instruction queue toward decode, and redirect flushing.
module rv32_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        halt,
  output logic        busy
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   issued_pc;
  logic [XLEN-1:0]   q_pc    [BUF_DEPTH];
  logic [XLEN-1:0]   q_instr [BUF_DEPTH];
  logic              head;
  logic [CNT_W-1:0]  count;
  logic              retract;

  logic              outstanding;
  logic              fire;
  logic              push;
  logic              pop;
  logic              tail;

  // Request/queue control decoded from registered state
  assign outstanding = (state == S_WAIT) | (state == S_DRAIN);
  assign imem_req    = (state == S_FETCH) & enable & ~retract &
                       ((SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(BUF_DEPTH));
  assign imem_addr   = fetch_pc;
  assign fire        = imem_req & imem_gnt;
  assign push        = (state == S_WAIT) & imem_rvalid & ~redirect_valid;
  assign pop         = if_valid & ~stall & ~redirect_valid;
  assign tail        = head ^ count[0];

  // Decode-side view of the queue head and status
  assign if_valid = (count != '0);
  assign if_pc    = q_pc[head];
  assign if_instr = q_instr[head];
  assign halt     = (state == S_IDLE);
  assign busy     = outstanding;

  // Sequencer state, fetch PC, queue and flush pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      issued_pc <= '0;
      head      <= 1'b0;
      count     <= '0;
      retract   <= 1'b0;
      flush     <= 1'b0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      flush   <= redirect_valid;
      // A redirect that catches an ungranted request withdraws it for a cycle
      retract <= redirect_valid & (state == S_FETCH) & ~fire;

      if (fire) begin
        fetch_pc  <= fetch_pc + XLEN'(4);
        issued_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~XLEN'(3);
      end

      if (redirect_valid) begin
        count <= '0;
        head  <= 1'b0;
      end else begin
        if (push) begin
          q_pc[tail]    <= issued_pc;
          q_instr[tail] <= imem_rdata;
        end
        if (pop) begin
          head <= ~head;
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (enable) state <= S_FETCH;
        end
        S_FETCH: begin
          if (fire) begin
            state <= redirect_valid ? S_DRAIN : S_WAIT;
          end else if (!enable && !redirect_valid) begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state <= (enable || redirect_valid) ? S_FETCH : S_IDLE;
          end else if (redirect_valid) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The in-flight wrong-path response ends the drain
          if (imem_rvalid) state <= enable ? S_FETCH : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_fetch_ctrl.sv
// Bench for rv32_fetch_ctrl: memory responder, PC/instruction scoreboard,
// per-cycle vector tables and hand-written redirect/halt/reset sequences.
`timescale 1ns/1ps
module tb_rv32_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        halt;
  logic        busy;

  rv32_fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .flush          (flush),
    .halt           (halt),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Values applied on the next tick
  logic        b_rst_n  = 1'b0;
  logic        b_enable = 1'b0;
  logic        b_stall  = 1'b0;
  logic        b_gnt    = 1'b1;
  logic        b_redir  = 1'b0;
  logic [31:0] b_rpc    = 32'h0;
  int          rv_delay = 1;

  // Memory responder and reference state
  logic        pend      = 1'b0;
  logic        wrong     = 1'b0;
  int          cnt       = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_fetch_pc = RST_PC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        rst;
    logic        en;
    logic        st;
    logic        gnt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        hlt;
    logic        bsy;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic rst, input logic en, input logic st, input logic gnt,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic hlt, input logic bsy);
    vec_t v;
    v.rst = rst; v.en = en; v.st = st; v.gnt = gnt; v.req = req;
    v.addr = addr; v.vld = vld; v.pc = pc; v.hlt = hlt; v.bsy = bsy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, respond as memory, check against the model
  task automatic tick();
    logic redir_now;
    logic pop_now;
    sb_t  e;
    @(posedge clk);
    #1;
    rst_n          = b_rst_n;
    enable         = b_enable;
    stall          = b_stall;
    imem_gnt       = b_gnt;
    redirect_valid = b_redir;
    redirect_pc    = b_rpc;
    b_redir        = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    if (pend) begin
      if (cnt > 0) cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend_addr);
      end
    end
    #1;
    redir_now = redirect_valid & rst_n;
    check("valid_vs_model", 32'(if_valid), 32'(sb.size() != 0));
    if (pend) check("one_outstanding", 32'(imem_req), 32'd0);
    if (imem_req) check("fetch_addr", imem_addr, exp_fetch_pc);
    pop_now = rst_n && !redir_now && if_valid && !stall;
    if (pop_now) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got pc 0x%08h expected no entry", if_pc);
      end else begin
        e = sb.pop_front();
        check("pop_pc", if_pc, e.pc);
        check("pop_instr", if_instr, e.instr);
      end
    end
    if (!rst_n) begin
      sb.delete();
      exp_fetch_pc = RST_PC;
      if (pend && imem_rvalid) pend = 1'b0;
      else if (pend) wrong = 1'b1;
    end else begin
      if (pend && imem_rvalid) begin
        if (!wrong && !redir_now) sb.push_back('{pc: pend_addr, instr: instr_of(pend_addr)});
        pend  = 1'b0;
        wrong = 1'b0;
      end
      if (imem_req && imem_gnt) begin
        pend         = 1'b1;
        wrong        = 1'b0;
        cnt          = rv_delay;
        pend_addr    = imem_addr;
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (redir_now) begin
        sb.delete();
        exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
        if (pend) wrong = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    b_rst_n = 1'b0; b_enable = 1'b0; b_stall = 1'b0; b_gnt = 1'b1;
    b_redir = 1'b0; rv_delay = 1;
    tick();
    tick();
    b_rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc, input int limit);
    int n;
    n = 0;
    tick();
    while (!if_valid && n < limit) begin
      tick();
      n++;
    end
    check({name, "_valid"}, 32'(if_valid), 32'd1);
    if (if_valid) check({name, "_pc"}, if_pc, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Reset state
    do_reset();
    tick();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, RST_PC);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc",    if_pc, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_halt",  32'(halt), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);

    // Streaming at zero wait states
    tbl.push_back(mk(1,1,0,1, 0,32'h00,0,32'h0,1,0));
    tbl.push_back(mk(0,1,0,1, 1,32'h00,0,32'h0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,32'h04,0,32'h0,0,1));
    tbl.push_back(mk(0,1,0,1, 1,32'h04,1,32'h0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,32'h08,0,32'h0,0,1));
    tbl.push_back(mk(0,1,0,1, 1,32'h08,1,32'h4,0,0));
    tbl.push_back(mk(0,1,0,1, 0,32'h0C,0,32'h0,0,1));
    tbl.push_back(mk(0,1,0,1, 1,32'h0C,1,32'h8,0,0));
    tbl.push_back(mk(0,1,0,1, 0,32'h10,0,32'h0,0,1));
    tbl.push_back(mk(0,1,0,1, 1,32'h10,1,32'hC,0,0));
    // Stall fills the queue, then release
    tbl.push_back(mk(1,1,1,1, 0,32'h00,0,32'h0,1,0));
    tbl.push_back(mk(0,1,1,1, 1,32'h00,0,32'h0,0,0));
    tbl.push_back(mk(0,1,1,1, 0,32'h04,0,32'h0,0,1));
    tbl.push_back(mk(0,1,1,1, 1,32'h04,1,32'h0,0,0));
    tbl.push_back(mk(0,1,1,1, 0,32'h08,1,32'h0,0,1));
    tbl.push_back(mk(0,1,1,1, 0,32'h08,1,32'h0,0,0));
    tbl.push_back(mk(0,1,1,1, 0,32'h08,1,32'h0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,32'h08,1,32'h0,0,0));
    tbl.push_back(mk(0,1,0,1, 1,32'h08,1,32'h4,0,0));
    tbl.push_back(mk(0,1,0,1, 0,32'h0C,0,32'h0,0,1));
    tbl.push_back(mk(0,1,0,1, 1,32'h0C,1,32'h8,0,0));
    // Grant withheld for three cycles
    tbl.push_back(mk(1,1,0,0, 0,32'h00,0,32'h0,1,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h00,0,32'h0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h00,0,32'h0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h00,0,32'h0,0,0));
    tbl.push_back(mk(0,1,0,1, 1,32'h00,0,32'h0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,32'h04,0,32'h0,0,1));
    tbl.push_back(mk(0,1,0,1, 1,32'h04,1,32'h0,0,0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      b_enable = tbl[i].en;
      b_stall  = tbl[i].st;
      b_gnt    = tbl[i].gnt;
      tick();
      check($sformatf("vec%0d_req", i),   32'(imem_req), 32'(tbl[i].req));
      check($sformatf("vec%0d_addr", i),  imem_addr, tbl[i].addr);
      check($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) check($sformatf("vec%0d_pc", i), if_pc, tbl[i].pc);
      check($sformatf("vec%0d_halt", i),  32'(halt), 32'(tbl[i].hlt));
      check($sformatf("vec%0d_busy", i),  32'(busy), 32'(tbl[i].bsy));
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'd0);
    end

    // Redirect in WAIT, stale response two cycles later
    do_reset();
    b_enable = 1'b1; rv_delay = 3;
    tick();
    tick();
    rv_delay = 1;
    b_redir = 1'b1; b_rpc = 32'h0000_0103;
    tick();
    tick();
    check("drain_flush",  32'(flush), 32'd1);
    check("drain_busy",   32'(busy), 32'd1);
    check("drain_req",    32'(imem_req), 32'd0);
    check("drain_valid",  32'(if_valid), 32'd0);
    tick();
    check("drain_flush_off", 32'(flush), 32'd0);
    tick();
    check("drain_refetch_req",  32'(imem_req), 32'd1);
    check("drain_refetch_addr", imem_addr, 32'h0000_0100);
    wait_valid("drain_target", 32'h0000_0100, 8);

    // Redirect coinciding with rvalid while the queue holds an entry
    do_reset();
    b_enable = 1'b1; b_stall = 1'b1;
    repeat (4) tick();
    check("rvredir_queued", 32'(if_valid), 32'd1);
    b_redir = 1'b1; b_rpc = 32'h0000_0200;
    tick();
    b_stall = 1'b0;
    tick();
    check("rvredir_cleared", 32'(if_valid), 32'd0);
    check("rvredir_flush",   32'(flush), 32'd1);
    check("rvredir_req",     32'(imem_req), 32'd1);
    check("rvredir_addr",    imem_addr, 32'h0000_0200);
    wait_valid("rvredir_target", 32'h0000_0200, 8);

    // Redirect while a request waits for grant retracts it
    do_reset();
    b_enable = 1'b1; b_gnt = 1'b0;
    tick();
    tick();
    b_redir = 1'b1; b_rpc = 32'h0000_0040;
    tick();
    check("retract_pre_req", 32'(imem_req), 32'd1);
    tick();
    check("retract_req",   32'(imem_req), 32'd0);
    check("retract_addr",  imem_addr, 32'h0000_0040);
    check("retract_flush", 32'(flush), 32'd1);
    b_gnt = 1'b1;
    tick();
    check("retract_reissue", 32'(imem_req), 32'd1);
    wait_valid("retract_target", 32'h0000_0040, 8);

    // Enable dropped during WAIT, then reset in WAIT followed by rvalid
    do_reset();
    b_enable = 1'b1;
    tick();
    tick();
    b_enable = 1'b0;
    tick();
    tick();
    check("halted_halt",  32'(halt), 32'd1);
    check("halted_busy",  32'(busy), 32'd0);
    check("halted_valid", 32'(if_valid), 32'd1);
    check("halted_pc",    if_pc, 32'h0000_0000);
    check("halted_req",   32'(imem_req), 32'd0);
    tick();
    check("halted_empty", 32'(if_valid), 32'd0);
    check("halted_stay",  32'(halt), 32'd1);
    b_enable = 1'b1; rv_delay = 2;
    tick();
    tick();
    check("midwait_req", 32'(imem_req), 32'd1);
    b_rst_n = 1'b0; b_enable = 1'b0;
    tick();
    b_rst_n = 1'b1;
    tick();
    tick();
    check("midwait_rst_valid", 32'(if_valid), 32'd0);
    check("midwait_rst_halt",  32'(halt), 32'd1);
    check("midwait_rst_busy",  32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_fetch_ctrl.md
Name: rv32_fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC/redirect logic and the code-memory port. It issues word fetches over a req/gnt/rvalid handshake, with at most one request outstanding, and buffers returned instructions with their PC in a 2-entry queue for decode. It applies decode stalls as back-pressure and discards wrong-path fetches on a branch/jump redirect.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded at reset
BUF_DEPTH, 2, instruction queue entries (fixed at 2; the issue rule below depends on it)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low; sampled only at posedge clk
enable  input  1  run request; 0 stops issuing new fetches
redirect_valid  input  1  branch/jump taken; single-cycle pulse
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
stall  input  1  decode cannot accept an instruction this cycle
imem_req  output  1  fetch request
imem_addr  output  32  fetch word address (byte address, 4-aligned)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
if_valid  output  1  queue head valid
if_instr  output  32  queue head instruction
if_pc  output  32  queue head PC
flush  output  1  registered; high the cycle after a redirect is accepted
halt  output  1  high in IDLE
busy  output  1  request outstanding or state DRAIN

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, fetch_pc=RESET_PC, queue empty, outstanding=0. Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, flush=0, halt=1, busy=0. Reset mid-transaction abandons the request; a later rvalid is ignored because the state is IDLE.
- States: IDLE, FETCH, WAIT, DRAIN.
- IDLE: halt=1. If enable=1, go to FETCH next cycle.
- FETCH: imem_req = enable & (count + outstanding < 2). imem_addr = fetch_pc.
  - req & gnt: next state WAIT; fetch_pc += 4 (wraps modulo 2^32); the issued PC is latched.
  - req & !gnt: imem_req and imem_addr stay stable until gnt.
  - enable=0 and nothing outstanding: go to IDLE.
- WAIT: imem_req=0.
  - imem_rvalid: push {latched PC, rdata}; go to FETCH, or to IDLE if enable=0.
- DRAIN: imem_req=0. The next imem_rvalid is discarded; then go to FETCH (or IDLE if enable=0).
- Throughput: one instruction per 2 cycles at zero memory wait states.
- Queue:
  - if_valid = count != 0; if_instr/if_pc show the head entry.
  - Pop when if_valid & ~stall. Push and pop in the same cycle are allowed.
  - The issue rule guarantees a push never hits a full queue.
- Redirect (highest priority, accepted in any state):
  - Queue cleared that cycle, so if_valid=0 next cycle.
  - fetch_pc <= redirect_pc & ~3; flush=1 for exactly the next cycle.
  - In FETCH without gnt: the request is retracted (imem_req=0 next cycle); stay in FETCH.
  - In FETCH with gnt the same cycle: a request is in flight, go to DRAIN.
  - In WAIT without rvalid: go to DRAIN.
  - In WAIT with rvalid the same cycle: data discarded; go to FETCH.
  - In DRAIN: stay in DRAIN.
  - In IDLE: only fetch_pc, queue and flush are affected.
- Stall with a redirect in the same cycle: the redirect wins; no pop occurs.
- enable=0 during WAIT: the outstanding fetch completes and is pushed, then go to IDLE. Queued entries stay deliverable while halted.
- busy = (state==WAIT) | (state==DRAIN).

Test Plan:
1. Reset, enable=1 from cycle 0, gnt=1, rvalid one cycle after gnt, stall=0 -> first if_valid in cycle 3 with if_pc=0x0; then if_pc 0x4, 0x8, 0xC every 2 cycles; if_instr matches rdata.
2. stall=1 held -> queue fills with PCs 0x0, 0x4; imem_req stays 0 while count=2. Release stall -> PCs delivered in order 0x0, 0x4, 0x8 with none lost or duplicated.
3. Redirect to 0x103 in WAIT, rvalid arriving 2 cycles later -> DRAIN; stale data discarded; flush pulses 1 cycle; next if_pc=0x100.
4. Redirect to 0x200 in the same cycle as rvalid -> data dropped; queue cleared; next imem_addr=0x200; next if_pc=0x200.
5. gnt withheld 3 cycles in FETCH -> imem_req=1 and imem_addr constant for all 4 cycles; fetch_pc advances only on the gnt cycle.
6. enable dropped in WAIT -> rvalid pushes the instruction, state goes to IDLE, halt=1, busy=0. A synchronous reset mid-WAIT, followed by rvalid, leaves if_valid=0.
